// File: rtl/raster_layer_scheduler.sv
// Layer scheduler for the raster pixel path: round-robin host writes into a shadow set,
// frame-boundary commit into the active set, and a 2-stage priority colour pipeline.
module raster_layer_scheduler #(
  parameter int          H_LINE   = 16,
  parameter int          V_LINE   = 5,
  parameter int          H_ACTIVE = 12,
  parameter int          V_ACTIVE = 4,
  parameter int          N_LAYER  = 4,
  parameter logic [23:0] BG_COLOR = 24'h000010,
  parameter int          LW       = (N_LAYER > 1) ? $clog2(N_LAYER) : 1
) (
  input  logic               iCLK,
  input  logic               iRST_n,
  input  logic [10:0]        iX_cnt,
  input  logic [9:0]         iY_cnt,
  input  logic [N_LAYER-1:0] iHit,
  input  logic [1:0]         iReq,
  input  logic [LW-1:0]      iWr_layer_a,
  input  logic [LW-1:0]      iWr_layer_b,
  input  logic               iWr_en_a,
  input  logic               iWr_en_b,
  input  logic [23:0]        iWr_color_a,
  input  logic [23:0]        iWr_color_b,
  input  logic               iCommit,
  output logic [1:0]         oGnt,
  output logic               oBusy,
  output logic               oCommit_done,
  output logic               oPix_de,
  output logic [23:0]        oPix_rgb,
  output logic               oFrame_start
);

  typedef enum logic {IDLE, PENDING} state_t;

  state_t state_q, state_d;
  logic   busy;
  logic   applyCommit;
  logic   frameEnd;

  logic   rr_q, rr_d;
  logic [1:0] gnt;
  logic [LW-1:0] wrLayer;
  logic          wrEn;
  logic [23:0]   wrColor;
  logic          wrValid;

  logic [N_LAYER-1:0] shadowEn_q, shadowEn_d;
  logic [23:0]        shadowColor_q [N_LAYER];
  logic [23:0]        shadowColor_d [N_LAYER];
  logic [N_LAYER-1:0] activeEn_q, activeEn_d;
  logic [23:0]        activeColor_q [N_LAYER];
  logic [23:0]        activeColor_d [N_LAYER];

  logic               de1_q, de1_d;
  logic               fs1_q, fs1_d;
  logic [23:0]        col1_q, col1_d;
  logic [N_LAYER-1:0] hitEn;

  logic               pixDe_q;
  logic [23:0]        pixRgb_q;
  logic               frameStart_q;
  logic               commitDone_q;

  assign frameEnd = (iX_cnt == 11'(H_LINE - 1)) && (iY_cnt == 10'(V_LINE - 1));

  // Commit FSM: state register
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (iCommit) state_d = PENDING;
      PENDING: if (frameEnd) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy        = (state_q == PENDING);
    applyCommit = (state_q == PENDING) && frameEnd;
  end

  // Writes are frozen while a commit is pending so the shadow set stays coherent
  always_comb begin
    gnt = 2'b00;
    if (!busy) begin
      case (iReq)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = rr_q ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end
  end

  always_comb begin
    rr_d = rr_q;
    if (gnt[0]) begin
      rr_d = 1'b1;
    end else if (gnt[1]) begin
      rr_d = 1'b0;
    end
  end

  always_comb begin
    wrValid = |gnt;
    wrLayer = gnt[1] ? iWr_layer_b : iWr_layer_a;
    wrEn    = gnt[1] ? iWr_en_b    : iWr_en_a;
    wrColor = gnt[1] ? iWr_color_b : iWr_color_a;
  end

  // Out-of-range layer indices are acknowledged but dropped
  always_comb begin
    shadowEn_d    = shadowEn_q;
    shadowColor_d = shadowColor_q;
    if (wrValid && (int'(wrLayer) < N_LAYER)) begin
      shadowEn_d[wrLayer]    = wrEn;
      shadowColor_d[wrLayer] = wrColor;
    end
  end

  always_comb begin
    activeEn_d    = activeEn_q;
    activeColor_d = activeColor_q;
    if (applyCommit) begin
      activeEn_d    = shadowEn_q;
      activeColor_d = shadowColor_q;
    end
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      rr_q         <= 1'b0;
      shadowEn_q   <= '0;
      activeEn_q   <= '0;
      commitDone_q <= 1'b0;
      for (int i = 0; i < N_LAYER; i++) begin
        shadowColor_q[i] <= '0;
        activeColor_q[i] <= '0;
      end
    end else begin
      rr_q          <= rr_d;
      shadowEn_q    <= shadowEn_d;
      shadowColor_q <= shadowColor_d;
      activeEn_q    <= activeEn_d;
      activeColor_q <= activeColor_d;
      commitDone_q  <= applyCommit;
    end
  end

  // Stage 1 reads the pre-commit active set, so the frame-end pixel keeps the old look
  always_comb begin
    hitEn  = iHit & activeEn_q;
    de1_d  = (iX_cnt < 11'(H_ACTIVE)) && (iY_cnt < 10'(V_ACTIVE));
    fs1_d  = (iX_cnt == 11'd0) && (iY_cnt == 10'd0);
    col1_d = '0;
    if (de1_d) begin
      col1_d = BG_COLOR;
      for (int i = N_LAYER - 1; i >= 0; i--) begin
        if (hitEn[i]) col1_d = activeColor_q[i];
      end
    end
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      de1_q        <= 1'b0;
      fs1_q        <= 1'b0;
      col1_q       <= '0;
      pixDe_q      <= 1'b0;
      pixRgb_q     <= '0;
      frameStart_q <= 1'b0;
    end else begin
      de1_q        <= de1_d;
      fs1_q        <= fs1_d;
      col1_q       <= col1_d;
      pixDe_q      <= de1_q;
      pixRgb_q     <= col1_q;
      frameStart_q <= fs1_q;
    end
  end

  assign oGnt         = gnt;
  assign oBusy        = busy;
  assign oCommit_done = commitDone_q;
  assign oPix_de      = pixDe_q;
  assign oPix_rgb     = pixRgb_q;
  assign oFrame_start = frameStart_q;

endmodule

// File: tb/tb_raster_layer_scheduler.sv
// Scoreboard bench for raster_layer_scheduler with three layers, so that layer index 3
// exercises the out-of-range write path.
module tb_raster_layer_scheduler;

  localparam int NL = 3;
  localparam int LWB = 2;
  localparam logic [23:0] BG = 24'h000010;

  typedef struct packed {
    logic        de;
    logic [23:0] rgb;
    logic        fs;
  } pix_t;

  logic           iCLK = 1'b0;
  logic           iRST_n = 1'b0;
  logic [10:0]    iX_cnt = '0;
  logic [9:0]     iY_cnt = '0;
  logic [NL-1:0]  iHit = '0;
  logic [1:0]     iReq = '0;
  logic [LWB-1:0] iWr_layer_a = '0, iWr_layer_b = '0;
  logic           iWr_en_a = 1'b0, iWr_en_b = 1'b0;
  logic [23:0]    iWr_color_a = '0, iWr_color_b = '0;
  logic           iCommit = 1'b0;
  logic [1:0]     oGnt;
  logic           oBusy, oCommit_done, oPix_de, oFrame_start;
  logic [23:0]    oPix_rgb;

  raster_layer_scheduler #(.N_LAYER(NL)) dut (
    .iCLK(iCLK), .iRST_n(iRST_n), .iX_cnt(iX_cnt), .iY_cnt(iY_cnt), .iHit(iHit),
    .iReq(iReq), .iWr_layer_a(iWr_layer_a), .iWr_layer_b(iWr_layer_b),
    .iWr_en_a(iWr_en_a), .iWr_en_b(iWr_en_b), .iWr_color_a(iWr_color_a),
    .iWr_color_b(iWr_color_b), .iCommit(iCommit), .oGnt(oGnt), .oBusy(oBusy),
    .oCommit_done(oCommit_done), .oPix_de(oPix_de), .oPix_rgb(oPix_rgb),
    .oFrame_start(oFrame_start)
  );

  always #5 iCLK = ~iCLK;

  int checks = 0;
  int passes = 0;

  int xPos = 0, yPos = 0;
  logic [1:0]     reqG = '0;
  logic [LWB-1:0] laA = '0, laB = '0;
  logic           enA = 1'b0, enB = 1'b0;
  logic [23:0]    colA = '0, colB = '0;
  logic           commitG = 1'b0;
  logic           hitRandom = 1'b1;
  logic [NL-1:0]  hitG = '0;

  logic        mShEn [NL];
  logic [23:0] mShCol [NL];
  logic        mActEn [NL];
  logic [23:0] mActCol [NL];
  logic        mPending = 1'b0;
  logic        mRrB = 1'b0;
  logic        mDoneExp = 1'b0;
  pix_t        pixQ [$];

  logic [1:0]  lastGnt;
  logic [23:0] lastRgb;
  logic        lastDe;
  int doneCount = 0, doneX = -1, doneY = -1;
  int busyCnt = 0, gntWhileBusy = 0;

  logic [1:0]  expSeq [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
  logic [1:0]  gotSeq [4];
  logic [2:0]  hitTbl [4] = '{3'b101, 3'b100, 3'b000, 3'b010};
  logic [23:0] expTbl [4] = '{24'hFF0000, 24'h00FF00, 24'h000010, 24'h000010};
  logic [23:0] rgbHist [6];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs === expv) passes++;
    else $display("[TB] FAIL %s: got %0h expected %0h (x=%0d y=%0d)", tag, obs, expv, xPos, yPos);
  endtask

  function automatic logic [1:0] modelGnt(input logic [1:0] r);
    if (mPending) return 2'b00;
    case (r)
      2'b01:   return 2'b01;
      2'b10:   return 2'b10;
      2'b11:   return mRrB ? 2'b10 : 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  function automatic pix_t expPix(input int x, input int y, input logic [NL-1:0] hit);
    pix_t p;
    p.de  = (x < 12) && (y < 4);
    p.fs  = (x == 0) && (y == 0);
    p.rgb = '0;
    if (p.de) begin
      p.rgb = BG;
      for (int i = NL - 1; i >= 0; i--) if (hit[i] && mActEn[i]) p.rgb = mActCol[i];
    end
    return p;
  endfunction

  task automatic clearModel();
    for (int i = 0; i < NL; i++) begin
      mShEn[i] = 1'b0; mShCol[i] = '0; mActEn[i] = 1'b0; mActCol[i] = '0;
    end
    mPending = 1'b0; mRrB = 1'b0; mDoneExp = 1'b0;
  endtask

  task automatic applyStimulus();
    iX_cnt = 11'(xPos);
    iY_cnt = 10'(yPos);
    iHit = hitRandom ? NL'($urandom_range(0, 7)) : hitG;
    iReq = reqG;
    iWr_layer_a = laA; iWr_en_a = enA; iWr_color_a = colA;
    iWr_layer_b = laB; iWr_en_b = enB; iWr_color_b = colB;
    iCommit = commitG;
    pixQ.push_back(expPix(xPos, yPos, iHit));
  endtask

  task automatic runCycle();
    logic [1:0] eg;
    pix_t e;
    logic fe;
    applyStimulus();
    @(negedge iCLK);
    eg = modelGnt(iReq);
    checkOutput("gnt", 32'(oGnt), 32'(eg));
    checkOutput("busy", 32'(oBusy), 32'(mPending));
    checkOutput("commit_done", 32'(oCommit_done), 32'(mDoneExp));
    e = pixQ.pop_front();
    checkOutput("pix_de", 32'(oPix_de), 32'(e.de));
    checkOutput("pix_rgb", 32'(oPix_rgb), 32'(e.rgb));
    checkOutput("frame_start", 32'(oFrame_start), 32'(e.fs));
    lastGnt = oGnt; lastRgb = oPix_rgb; lastDe = oPix_de;
    if (oCommit_done) begin doneCount++; doneX = xPos; doneY = yPos; end
    if (oBusy) begin busyCnt++; if (oGnt != 2'b00) gntWhileBusy++; end
    fe = (xPos == 15) && (yPos == 4);
    mDoneExp = mPending && fe;
    if (mPending && fe) begin
      for (int i = 0; i < NL; i++) begin mActEn[i] = mShEn[i]; mActCol[i] = mShCol[i]; end
      mPending = 1'b0;
    end else if (!mPending && iCommit) begin
      mPending = 1'b1;
    end
    if (eg[0] && int'(iWr_layer_a) < NL) begin mShEn[iWr_layer_a] = iWr_en_a; mShCol[iWr_layer_a] = iWr_color_a; end
    if (eg[1] && int'(iWr_layer_b) < NL) begin mShEn[iWr_layer_b] = iWr_en_b; mShCol[iWr_layer_b] = iWr_color_b; end
    if (eg != 2'b00) mRrB = eg[0];
    @(posedge iCLK);
    #1;
    xPos++;
    if (xPos == 16) begin xPos = 0; yPos++; if (yPos == 5) yPos = 0; end
  endtask

  task automatic runN(input int n);
    for (int i = 0; i < n; i++) runCycle();
  endtask

  task automatic runUntil(input int tx, input int ty);
    int n = 0;
    while (!(xPos == tx && yPos == ty) && n < 200) begin runCycle(); n++; end
    checkOutput("reach_xy", 32'(xPos == tx && yPos == ty), 32'd1);
  endtask

  task automatic doReset();
    iRST_n = 1'b0;
    commitG = 1'b0; iCommit = 1'b0;
    xPos = 0; yPos = 0;
    iReq = reqG;
    clearModel();
    pixQ.delete();
    repeat (2) @(posedge iCLK);
    #1;
    checkOutput("rst_gnt", 32'(oGnt), 32'(modelGnt(reqG)));
    checkOutput("rst_busy", 32'(oBusy), 32'd0);
    checkOutput("rst_done", 32'(oCommit_done), 32'd0);
    checkOutput("rst_de", 32'(oPix_de), 32'd0);
    checkOutput("rst_rgb", 32'(oPix_rgb), 32'd0);
    checkOutput("rst_fs", 32'(oFrame_start), 32'd0);
    @(posedge iCLK);
    #1;
    iRST_n = 1'b1;
    pixQ.push_back('0);
    pixQ.push_back('0);
    doneCount = 0;
  endtask

  initial begin
    $display("[TB] raster_layer_scheduler bench start");
    reqG = 2'b11;
    laA = 2'd1; enA = 1'b1; colA = 24'h0000FF;
    laB = 2'd2; enB = 1'b1; colB = 24'h00FF00;
    doReset();

    // Both requesters held: strict alternation starting at A
    for (int i = 0; i < 4; i++) begin runCycle(); gotSeq[i] = lastGnt; end
    for (int i = 0; i < 4; i++) checkOutput("gnt_seq", 32'(gotSeq[i]), 32'(expSeq[i]));

    reqG = 2'b01; laA = 2'd0; enA = 1'b1; colA = 24'hFF0000;
    runN(1);
    reqG = 2'b00;
    runUntil(5, 2);
    commitG = 1'b1; runN(1); commitG = 1'b0;
    doneX = -1; doneY = -1;
    runUntil(0, 0);
    hitRandom = 1'b0; hitG = 3'b001; runN(1);
    hitRandom = 1'b1; runN(2);
    checkOutput("rgb_after_commit", 32'(lastRgb), 32'hFF0000);
    checkOutput("done_x", 32'(doneX), 32'd0);
    checkOutput("done_y", 32'(doneY), 32'd0);

    // Out-of-range layer write is acked, then layer 1 is disabled
    reqG = 2'b01; laA = 2'd3; enA = 1'b1; colA = 24'h123456; runN(1);
    checkOutput("oor_gnt", 32'(lastGnt), 32'h1);
    reqG = 2'b10; laB = 2'd1; enB = 1'b0; colB = 24'h0; runN(1);
    reqG = 2'b00;
    runUntil(15, 4);
    commitG = 1'b1; runN(1); commitG = 1'b0;
    busyCnt = 0; gntWhileBusy = 0;
    reqG = 2'b10; laB = 2'd2; enB = 1'b0; colB = 24'h0;
    runUntil(7, 2);
    commitG = 1'b1; runN(1); commitG = 1'b0;
    runUntil(15, 4);
    runN(2);
    reqG = 2'b00;
    checkOutput("busy_cycles", 32'(busyCnt), 32'd80);
    checkOutput("gnt_while_busy", 32'(gntWhileBusy), 32'd0);

    runUntil(0, 1);
    hitRandom = 1'b0;
    for (int i = 0; i < 6; i++) begin
      hitG = (i < 4) ? hitTbl[i] : 3'b000;
      runCycle();
      rgbHist[i] = lastRgb;
    end
    for (int i = 0; i < 4; i++) checkOutput("prio_rgb", 32'(rgbHist[i + 2]), 32'(expTbl[i]));
    runUntil(12, 1);
    hitG = 3'b111; runN(1); hitG = 3'b000; runN(2);
    checkOutput("blank_de", 32'(lastDe), 32'd0);
    checkOutput("blank_rgb", 32'(lastRgb), 32'd0);
    hitRandom = 1'b1;
    runN(80);

    // Reset in the middle of a pending commit must abort it
    runUntil(3, 1);
    commitG = 1'b1; runN(1); commitG = 1'b0;
    runN(5);
    checkOutput("pending_before_rst", 32'(oBusy), 32'd1);
    reqG = 2'b00;
    doReset();
    hitRandom = 1'b0; hitG = 3'b001; runN(1);
    hitRandom = 1'b1; runN(2);
    checkOutput("bg_after_rst", 32'(lastRgb), 32'(BG));
    runN(160);
    checkOutput("no_done_after_rst", 32'(doneCount), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
